sort_ctrl: RTL

Sequencing controller for the sorting datapath. Owns a bank of K enabled N-bit registers (reset-to-zero, load-on-enable) and drives their enables and muxes through three phases: serial load over a valid/ready stream, in-place odd-even transposition sort in ascending unsigned order, and serial drain over a second valid/ready stream. It sits between the input stream source and the downstream consumer of sorted results.

---
 rtl/sort_ctrl_pkg.sv | 15 +
 rtl/sort_ctrl_if.sv | 24 ++
 rtl/sort_ctrl_cmp_swap.sv | 15 +
 rtl/sort_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sort_ctrl_pkg.sv
// Shared types and sizing helpers for the sort controller.
// Holds the phase enum and the index-width rule (ceil log2 of K, at least 1 bit).
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int idx_width(input int k);
        return (k < 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/sort_ctrl_if.sv
// Load and drain valid/ready streams plus status flags of the sort controller.
// The slave modport is the controller side; the master modport is the source/consumer side.
interface sort_ctrl_if #(
    parameter int N = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         busy;
    logic         done;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/sort_ctrl_cmp_swap.sv
// Unsigned compare-and-order of one adjacent pair; purely combinational.
// Latency 0; no flow control. Equal operands are not swapped.
module cmp_swap #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] lo_o,
    output logic [N-1:0] hi_o,
    output logic         swapped_o
);
    assign swapped_o = (a_i > b_i);
    assign lo_o      = swapped_o ? b_i : a_i;
    assign hi_o      = swapped_o ? a_i : b_i;
endmodule

// File: rtl/sort_ctrl.sv
// Load K words, odd-even transposition sort in place, drain smallest first.
// Latency: first out_valid K+1 cycles after the last accept (fewer with SORT_EARLY_EXIT_EN).
// Backpressure: out_ready stalls the drain with out_data held; in_ready is low outside LOAD.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst,
    sort_ctrl_if.slave   bus
);
    localparam int IW = idx_width(K);
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    if (K < 2) begin : g_bad_k
        $error("sort_ctrl: K must be at least 2");
    end

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] pass_q;
    logic          done_q;
    logic          sort_last;

    logic [N-1:0]  bank_q [K];
    logic [N-1:0]  bank_d [K];
    logic [N-1:0]  lo     [K-1];
    logic [N-1:0]  hi     [K-1];
    logic [K-2:0]  swp;
    logic [K-2:0]  pair_act;
    logic [K-1:0]  lo_we;
    logic [K-1:0]  hi_we;
    logic [N-1:0]  lo_v   [K];
    logic [N-1:0]  hi_v   [K];

    for (genvar i = 0; i < K - 1; i++) begin : g_cs
        cmp_swap #(.N(N)) u_cs (
            .a_i       (bank_q[i]),
            .b_i       (bank_q[i+1]),
            .lo_o      (lo[i]),
            .hi_o      (hi[i]),
            .swapped_o (swp[i])
        );
    end

    always_comb begin
        pair_act = '0;
        for (int i = 0; i < K - 1; i++) begin
            pair_act[i] = (state_q == SORT) && (pass_q[0] == 1'(i % 2));
        end
    end

    // A register is written only when its active pair actually swaps;
    // writing back an unchanged value would be a no-op anyway.
    for (genvar j = 0; j < K; j++) begin : g_map
        if (j < K - 1) begin : g_lo
            assign lo_we[j] = pair_act[j] & swp[j];
            assign lo_v[j]  = lo[j];
        end else begin : g_lo_none
            assign lo_we[j] = 1'b0;
            assign lo_v[j]  = '0;
        end
        if (j > 0) begin : g_hi
            assign hi_we[j] = pair_act[j-1] & swp[j-1];
            assign hi_v[j]  = hi[j-1];
        end else begin : g_hi_none
            assign hi_we[j] = 1'b0;
            assign hi_v[j]  = '0;
        end
    end

    always_comb begin
        for (int j = 0; j < K; j++) begin
            bank_d[j] = bank_q[j];
            if (state_q == LOAD && bus.in_valid && idx_q == IW'(j)) begin
                bank_d[j] = bus.in_data;
            end else if (lo_we[j]) begin
                bank_d[j] = lo_v[j];
            end else if (hi_we[j]) begin
                bank_d[j] = hi_v[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < K; j++) bank_q[j] <= '0;
        end else begin
            for (int j = 0; j < K; j++) bank_q[j] <= bank_d[j];
        end
    end

`ifdef SORT_EARLY_EXIT_EN
    // Two back-to-back quiet passes (one of each parity) mean the bank is ordered.
    logic quiet_q;
    logic pass_quiet;

    assign pass_quiet = ~|(swp & pair_act);
    assign sort_last  = (pass_q == LAST) || (quiet_q && pass_quiet);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quiet_q <= 1'b0;
        end else if (state_q == SORT && !sort_last) begin
            quiet_q <= pass_quiet;
        end else begin
            quiet_q <= 1'b0;
        end
    end
`else
    assign sort_last = (pass_q == LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            pass_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (bus.in_valid) begin
                        if (idx_q == LAST) begin
                            idx_q   <= '0;
                            pass_q  <= '0;
                            state_q <= SORT;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                SORT: begin
                    if (sort_last) begin
                        pass_q  <= '0;
                        state_q <= DRAIN;
                    end else begin
                        pass_q <= pass_q + IW'(1);
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (idx_q == LAST) begin
                            idx_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= LOAD;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = (state_q == DRAIN) ? bank_q[idx_q] : '0;
    assign bus.busy      = (state_q != LOAD);
    assign bus.done      = done_q;

endmodule
